// File: rtl/fixflo_arbiter.sv
// Two-requester round-robin arbiter/sequencer for the shared 16-bit fixed/float datapath.
// Define FIXFLO_FMUL_EN to build the float multiplier; without it op 11 returns the illegal-op flag.
module fixflo_arbiter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid_a,
  input  logic        req_valid_b,
  output logic        req_ready_a,
  output logic        req_ready_b,
  input  logic [1:0]  req_op_a,
  input  logic [1:0]  req_op_b,
  input  logic [15:0] req_num1_a,
  input  logic [15:0] req_num2_a,
  input  logic [15:0] req_num1_b,
  input  logic [15:0] req_num2_b,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [15:0] rsp_result,
  output logic [4:0]  rsp_flags,
  output logic        busy
);

  typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

  state_e      state_q, state_d;
  logic        prio_q, prio_d;
  logic [1:0]  op_q;
  logic [15:0] num1_q, num2_q;
  logic        id_q;
  logic [15:0] res_q;
  logic [4:0]  flags_q;
  logic        rid_q;

  logic        grant_a, grant_b, accept;
  logic [16:0] fxa_sum;
  logic [31:0] fxm_prod;
  logic [15:0] fadd_res;
  logic        fadd_ovf, fadd_zero, fadd_nan;
  logic [15:0] exec_res;
  logic [4:0]  exec_flags;

  // prio_q = 1 means B wins a tie.
  assign grant_a     = req_valid_a & (~req_valid_b | ~prio_q);
  assign grant_b     = req_valid_b & (~req_valid_a | prio_q);
  assign req_ready_a = rst_n & (state_q == StIdle) & grant_a;
  assign req_ready_b = rst_n & (state_q == StIdle) & grant_b;
  assign accept      = req_ready_a | req_ready_b;

  always_comb begin
    state_d = state_q;
    prio_d  = prio_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = StExec;
          prio_d  = ~req_ready_b;
        end
      end
      StExec:  state_d = StResp;
      StResp:  if (rsp_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      prio_q  <= 1'b0;
      op_q    <= 2'b00;
      num1_q  <= 16'h0000;
      num2_q  <= 16'h0000;
      id_q    <= 1'b0;
      res_q   <= 16'h0000;
      flags_q <= 5'b00000;
      rid_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      if (accept) begin
        op_q   <= req_ready_b ? req_op_b : req_op_a;
        num1_q <= req_ready_b ? req_num1_b : req_num1_a;
        num2_q <= req_ready_b ? req_num2_b : req_num2_a;
        id_q   <= req_ready_b;
      end
      if (state_q == StExec) begin
        res_q   <= exec_res;
        flags_q <= exec_flags;
        rid_q   <= id_q;
      end
    end
  end

  // Unsigned Q8.8 fixed-point units.
  assign fxa_sum  = {1'b0, num1_q} + {1'b0, num2_q};
  assign fxm_prod = {16'h0000, num1_q} * {16'h0000, num2_q};

  // Half-precision adder: truncating, subnormals flushed to zero.
  always_comb begin : fadd
    logic [15:0]       big, sml;
    logic [10:0]       big_m, sml_m, norm;
    logic [11:0]       sum;
    logic [4:0]        diff;
    logic signed [6:0] fexp;
    fadd_res  = 16'h0000;
    fadd_ovf  = 1'b0;
    fadd_zero = 1'b0;
    fadd_nan  = 1'b0;
    if (num1_q[14:0] >= num2_q[14:0]) begin
      big = num1_q;
      sml = num2_q;
    end else begin
      big = num2_q;
      sml = num1_q;
    end
    big_m = (big[14:10] == 5'd0) ? 11'd0 : {1'b1, big[9:0]};
    sml_m = (sml[14:10] == 5'd0) ? 11'd0 : {1'b1, sml[9:0]};
    diff  = big[14:10] - sml[14:10];
    sml_m = sml_m >> diff;
    sum   = (big[15] ^ sml[15]) ? {1'b0, big_m} - {1'b0, sml_m} : {1'b0, big_m} + {1'b0, sml_m};
    fexp  = {2'b00, big[14:10]};
    if (sum[11]) begin
      norm = sum[11:1];
      fexp = fexp + 7'sd1;
    end else begin
      norm = sum[10:0];
      for (int i = 0; i < 10; i++) begin
        if (!norm[10] && norm != 11'd0) begin
          norm = {norm[9:0], 1'b0};
          fexp = fexp - 7'sd1;
        end
      end
    end
    // A NaN operand always has the larger magnitude, so only big needs testing.
    if ((&big[14:10] & |big[9:0]) |
        ((big[14:0] == 15'h7C00) & (sml[14:0] == 15'h7C00) & (big[15] ^ sml[15]))) begin
      fadd_nan = 1'b1;
      fadd_res = 16'h7E00;
    end else if (big[14:0] == 15'h7C00) begin
      fadd_res = big;
    end else if (norm == 11'd0 || fexp <= 7'sd0) begin
      fadd_zero = 1'b1;
    end else if (fexp >= 7'sd31) begin
      fadd_ovf = 1'b1;
      fadd_res = {big[15], 5'h1F, 10'h000};
    end else begin
      fadd_res = {big[15], fexp[4:0], norm[9:0]};
    end
  end

`ifdef FIXFLO_FMUL_EN
  logic [21:0] fmul_prod;
  logic [15:0] fmul_res;
  logic        fmul_ovf;
  logic        unused_fmul_lo;

  assign fmul_prod      = {11'd0, 1'b1, num1_q[9:0]} * {11'd0, 1'b1, num2_q[9:0]};
  assign unused_fmul_lo = ^fmul_prod[9:0];

  always_comb begin : fmul
    logic signed [7:0] mexp;
    logic [9:0]        frac;
    logic              sgn;
    sgn      = num1_q[15] ^ num2_q[15];
    mexp     = $signed({3'b000, num1_q[14:10]}) + $signed({3'b000, num2_q[14:10]}) - 8'sd15;
    frac     = fmul_prod[19:10];
    fmul_ovf = 1'b0;
    if (fmul_prod[21]) begin
      frac = fmul_prod[20:11];
      mexp = mexp + 8'sd1;
    end
    if (num1_q[14:10] == 5'd0 || num2_q[14:10] == 5'd0 || mexp <= 8'sd0) begin
      fmul_res = {sgn, 15'h0000};
    end else if (mexp >= 8'sd31) begin
      fmul_ovf = 1'b1;
      fmul_res = {sgn, 5'h1F, 10'h000};
    end else begin
      fmul_res = {sgn, mexp[4:0], frac};
    end
  end
`endif

  always_comb begin
    exec_res   = 16'h0000;
    exec_flags = 5'b00000;
    unique case (op_q)
      2'b00: begin
        exec_res      = fxa_sum[15:0];
        exec_flags[0] = fxa_sum[16];
      end
      2'b01: begin
        exec_res      = fxm_prod[23:8];
        exec_flags[0] = |fxm_prod[31:24];
        exec_flags[1] = |fxm_prod[7:0];
      end
      2'b10: begin
        exec_res      = fadd_res;
        exec_flags[0] = fadd_ovf;
        exec_flags[2] = fadd_zero;
        exec_flags[3] = fadd_nan;
      end
      default: begin
`ifdef FIXFLO_FMUL_EN
        exec_res      = fmul_res;
        exec_flags[0] = fmul_ovf;
`else
        exec_flags[4] = 1'b1;
`endif
      end
    endcase
  end

  assign rsp_valid  = (state_q == StResp);
  assign busy       = (state_q != StIdle);
  assign rsp_id     = rid_q;
  assign rsp_result = res_q;
  assign rsp_flags  = flags_q;

endmodule
